grid_sync_ctrl: RTL and testbench

- Sequences grid-wide synchronous branches.
- Each PE in a grid posts its local branch condition with a request. The block barriers all participating PEs, then publishes the OR-able condition vector (cond_state) that each PE's branch comparator reduces for its sync-beq decision.
- Releases all PEs together with a one-cycle acknowledge. A timeout guards against PEs that never arrive.

---
 rtl/grid_sync_if.sv | 21 ++
 rtl/grid_sync_ctrl.sv | 164 ++++++++++++++++
 tb/tb_grid_sync_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_sync_if.sv
// Grid synchronous-branch request/acknowledge bundle.
// PEs act as master, the sync controller as slave.
interface grid_sync_if #(
    parameter int N_PE = 16
);
    logic [N_PE-1:0] sync_req;
    logic [N_PE-1:0] sync_cond;
    logic [N_PE-1:0] sync_ack;

    modport master (
        output sync_req,
        output sync_cond,
        input  sync_ack
    );

    modport slave (
        input  sync_req,
        input  sync_cond,
        output sync_ack
    );
endinterface

// File: rtl/grid_sync_ctrl.sv
// Grid-wide barrier for synchronous branches: collects PE conditions,
// publishes the combined vector and releases all PEs together.
module grid_sync_ctrl #(
    parameter int N_PE = 16,
    parameter int TO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_PE-1:0]  pe_mask,
    input  logic [TO_W-1:0]  timeout_cycles,
    grid_sync_if.slave       bus,
    output logic [N_PE-1:0]  cond_state,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clr,
    output logic [7:0]       sync_epoch
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RELEASE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [N_PE-1:0] mask_q;
    logic [N_PE-1:0] arrived_q;
    logic [N_PE-1:0] cond_q;
    logic [N_PE-1:0] ack_q;
    logic [TO_W-1:0] to_cnt;

    logic [N_PE-1:0] qreq;
    logic [N_PE-1:0] fresh;
    logic            start;
    logic            complete;
    logic            expire;
    logic            waiting;
    logic            leave;

    // Only first arrivals contribute a condition; later edges are ignored.
    assign qreq  = bus.sync_req & mask_q;
    assign fresh = qreq & ~arrived_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (complete || expire) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (leave) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        start    = 1'b0;
        complete = 1'b0;
        expire   = 1'b0;
        waiting  = 1'b0;
        leave    = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                start = |(bus.sync_req & pe_mask);
            end
            COLLECT: begin
                busy     = 1'b1;
                complete = ((arrived_q | qreq) == mask_q);
                // Completion on the timeout cycle wins over the timeout.
                expire   = !complete
                         && (timeout_cycles != '0)
                         && (to_cnt == timeout_cycles - TO_W'(1));
                waiting  = !complete && !expire;
            end
            RELEASE: begin
                busy  = 1'b1;
                leave = (qreq == '0);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q     <= '0;
            arrived_q  <= '0;
            cond_q     <= '0;
            ack_q      <= '0;
            to_cnt     <= '0;
            cond_state <= '0;
            sync_epoch <= '0;
        end else begin
            ack_q <= '0;
            unique case (1'b1)
                start: begin
                    mask_q    <= pe_mask;
                    arrived_q <= bus.sync_req & pe_mask;
                    cond_q    <= bus.sync_req & bus.sync_cond & pe_mask;
                    to_cnt    <= '0;
                end
                complete: begin
                    ack_q      <= mask_q;
                    cond_state <= cond_q | (fresh & bus.sync_cond);
                    sync_epoch <= sync_epoch + 8'd1;
                end
                expire: begin
                    ack_q      <= arrived_q;
                    cond_state <= cond_q;
                    sync_epoch <= sync_epoch + 8'd1;
                end
                waiting: begin
                    arrived_q <= arrived_q | qreq;
                    cond_q    <= cond_q | (fresh & bus.sync_cond);
                    to_cnt    <= to_cnt + TO_W'(1);
                end
                leave: begin
                    arrived_q <= '0;
                    cond_q    <= '0;
                    to_cnt    <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (expire) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

    assign bus.sync_ack = ack_q;

endmodule

// File: tb/tb_grid_sync_ctrl.sv
// Directed bench for grid_sync_ctrl with a per-PE behavioural model
// compared every cycle, plus hand-computed literal checks.
module tb_grid_sync_ctrl;
    localparam int N = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  pe_mask;
    logic [TW-1:0] timeout_cycles;
    logic [N-1:0]  cond_state;
    logic          busy;
    logic          err_timeout;
    logic          err_clr;
    logic [7:0]    sync_epoch;

    grid_sync_if #(.N_PE(N)) bus ();

    grid_sync_ctrl #(.N_PE(N), .TO_W(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_mask        (pe_mask),
        .timeout_cycles (timeout_cycles),
        .bus            (bus),
        .cond_state     (cond_state),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .err_clr        (err_clr),
        .sync_epoch     (sync_epoch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-PE bookkeeping of who joined, their
    // first-seen condition and how long the barrier has waited.
    int         phase;
    int         waited;
    bit         part [N];
    bit         here [N];
    bit         cnd  [N];
    bit         any;
    bit         all_in;
    bit         fired;
    logic [N-1:0] nack;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_cond;
    logic         e_err;
    logic [7:0]   e_epoch;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0;
            waited = 0;
            for (int i = 0; i < N; i++) begin
                part[i] = 0;
                here[i] = 0;
                cnd[i] = 0;
            end
            e_ack = '0;
            e_cond = '0;
            e_err = 1'b0;
            e_epoch = '0;
        end else begin
            nack = '0;
            fired = 0;
            case (phase)
                0: begin
                    any = 0;
                    for (int i = 0; i < N; i++)
                        if (pe_mask[i] && bus.sync_req[i]) any = 1;
                    if (any) begin
                        phase = 1;
                        waited = 0;
                        for (int i = 0; i < N; i++) begin
                            part[i] = pe_mask[i];
                            here[i] = part[i] && bus.sync_req[i];
                            cnd[i] = here[i] && bus.sync_cond[i];
                        end
                    end
                end
                1: begin
                    all_in = 1;
                    for (int i = 0; i < N; i++)
                        if (part[i] && !here[i] && !bus.sync_req[i])
                            all_in = 0;
                    if (all_in) begin
                        for (int i = 0; i < N; i++) begin
                            if (part[i] && !here[i]) cnd[i] = bus.sync_cond[i];
                            nack[i] = part[i];
                            e_cond[i] = cnd[i];
                        end
                        e_epoch = e_epoch + 8'd1;
                        phase = 2;
                    end else if (timeout_cycles != 0
                                 && waited + 1 == int'(timeout_cycles)) begin
                        for (int i = 0; i < N; i++) begin
                            nack[i] = here[i];
                            e_cond[i] = cnd[i];
                        end
                        fired = 1;
                        e_epoch = e_epoch + 8'd1;
                        phase = 2;
                    end else begin
                        for (int i = 0; i < N; i++)
                            if (part[i] && bus.sync_req[i] && !here[i]) begin
                                here[i] = 1;
                                cnd[i] = bus.sync_cond[i];
                            end
                        waited++;
                    end
                end
                default: begin
                    any = 0;
                    for (int i = 0; i < N; i++)
                        if (part[i] && bus.sync_req[i]) any = 1;
                    if (!any) begin
                        phase = 0;
                        for (int i = 0; i < N; i++) begin
                            here[i] = 0;
                            cnd[i] = 0;
                        end
                    end
                end
            endcase
            if (fired) e_err = 1'b1;
            else if (err_clr) e_err = 1'b0;
            e_ack = nack;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("m_ack", 32'(bus.sync_ack), 32'(e_ack));
            chk("m_cond", 32'(cond_state), 32'(e_cond));
            chk("m_busy", 32'(busy), 32'(phase != 0));
            chk("m_err", 32'(err_timeout), 32'(e_err));
            chk("m_epoch", 32'(sync_epoch), 32'(e_epoch));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] cond);
        bus.sync_req = req;
        bus.sync_cond = cond;
    endtask

    initial begin
        rst = 1'b1;
        pe_mask = '0;
        timeout_cycles = '0;
        err_clr = 1'b0;
        drive('0, '0);
        #12;
        chk("rst_ack", 32'(bus.sync_ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_epoch", 32'(sync_epoch), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        step();

        // basic barrier
        pe_mask = 16'h000F;
        drive(16'h0001, 16'h0001);
        step();
        chk("bb_busy", 32'(busy), 32'h1);
        step();
        drive(16'h000F, 16'h0001);
        step();
        chk("bb_ack", 32'(bus.sync_ack), 32'h000F);
        chk("bb_cond", 32'(cond_state), 32'h0001);
        chk("bb_epoch", 32'(sync_epoch), 32'h1);
        step();
        chk("bb_ack_drop", 32'(bus.sync_ack), 32'h0);
        drive('0, '0);
        step();
        chk("bb_idle", 32'(busy), 32'h0);

        // simultaneous arrival
        pe_mask = 16'hFFFF;
        drive(16'hFFFF, 16'h8001);
        step();
        chk("sa_busy", 32'(busy), 32'h1);
        chk("sa_noack", 32'(bus.sync_ack), 32'h0);
        step();
        chk("sa_ack", 32'(bus.sync_ack), 32'hFFFF);
        chk("sa_cond", 32'(cond_state), 32'h8001);
        drive('0, '0);
        step();
        chk("sa_idle", 32'(busy), 32'h0);

        // unmasked PE5 and stale requests
        pe_mask = 16'h0003;
        drive(16'h0023, 16'h0000);
        step();
        step();
        chk("us_ack", 32'(bus.sync_ack), 32'h0003);
        chk("us_cond", 32'(cond_state), 32'h0000);
        step();
        chk("us_stale_busy", 32'(busy), 32'h1);
        chk("us_stale_ack", 32'(bus.sync_ack), 32'h0);
        drive(16'h0020, 16'h0000);
        step();
        step();
        chk("us_idle", 32'(busy), 32'h0);
        chk("us_epoch", 32'(sync_epoch), 32'h3);
        drive('0, '0);

        // timeout, with err_clr colliding on the set edge
        pe_mask = 16'h0007;
        timeout_cycles = 16'd4;
        drive(16'h0003, 16'h0002);
        step();
        step();
        step();
        step();
        chk("to_wait", 32'(bus.sync_ack), 32'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_ack", 32'(bus.sync_ack), 32'h0003);
        chk("to_err", 32'(err_timeout), 32'h1);
        chk("to_cond", 32'(cond_state), 32'h0002);
        chk("to_epoch", 32'(sync_epoch), 32'h4);
        drive('0, '0);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_clr", 32'(err_timeout), 32'h0);

        // last arrival on the timeout cycle completes normally
        drive(16'h0003, 16'h0000);
        step();
        step();
        step();
        step();
        drive(16'h0007, 16'h0004);
        step();
        chk("tb_ack", 32'(bus.sync_ack), 32'h0007);
        chk("tb_err", 32'(err_timeout), 32'h0);
        chk("tb_cond", 32'(cond_state), 32'h0004);
        chk("tb_epoch", 32'(sync_epoch), 32'h5);
        drive('0, '0);
        step();
        timeout_cycles = '0;

        // empty mask never starts
        pe_mask = 16'h0000;
        drive(16'hFFFF, 16'hFFFF);
        step();
        step();
        step();
        chk("zm_busy", 32'(busy), 32'h0);
        drive('0, '0);

        // asynchronous reset in the middle of COLLECT
        pe_mask = 16'h000F;
        drive(16'h0001, 16'h0001);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_epoch", 32'(sync_epoch), 32'h0);
        chk("ar_cond", 32'(cond_state), 32'h0);
        drive('0, '0);
        step();
        rst = 1'b0;
        step();
        drive(16'h000F, 16'h0000);
        step();
        step();
        chk("ar_ack", 32'(bus.sync_ack), 32'h000F);
        chk("ar_epoch1", 32'(sync_epoch), 32'h1);
        drive('0, '0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
